// File: rtl/dmem_ring_pkg.sv
// Shared types and defaults for the multi-channel ring data memory.
package dmem_ring_pkg;

  localparam int DATABITS      = 16;
  localparam int DMEMSIZE      = 16;
  localparam int DMEM_CHANNELS = 4;

  typedef enum logic [2:0] {
    DMEM_NOP     = 3'd0,
    DMEM_WRITE   = 3'd1,
    DMEM_READ    = 3'd2,
    DMEM_PUSH    = 3'd3,
    DMEM_READREL = 3'd4,
    DMEM_CLR     = 3'd5
  } dmem_ring_cmd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dmem_ring_state_t;

  // Select width that never collapses to zero bits for a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_ring_wrap.sv
// Modulo-DEPTH pointer arithmetic: next slot after ptr, and ptr minus an age.
// DEPTH need not be a power of two, so wrap is explicit rather than masked.
module dmem_ring_wrap #(
  parameter int DEPTH = 5,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [AW-1:0] ptr,
  input  logic [AW-1:0] off,
  output logic [AW-1:0] inc,
  output logic [AW-1:0] sub
);

  // Increment with wrap at DEPTH-1; subtract with borrow back into range.
  // off is assumed < DEPTH; the caller discards results for larger ages.
  always_comb begin
    inc = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    if (ptr >= off) begin
      sub = ptr - off;
    end else begin
      sub = AW'({1'b0, ptr} + (AW+1)'(DEPTH) - {1'b0, off});
    end
  end

endmodule

// File: rtl/dmem_ring.sv
// Per-channel sample store usable as absolute RAM or as a circular delay
// line with age-relative reads. Includes a serial scan chain over all memory
// bits and a per-channel clear sweep that reports busy while it runs.
//
// Command handshake: cmd_in is taken on a rising edge only when sde_in=0 and
// busy_out=0; otherwise it is dropped (never queued). A taken READ/READREL
// produces d_out and a one-cycle valid_out pulse after that same edge.
module dmem_ring
  import dmem_ring_pkg::*;
#(
  parameter int WIDTH    = DATABITS,
  parameter int DEPTH    = DMEMSIZE,
  parameter int CHANNELS = DMEM_CHANNELS,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = sel_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sde_in,
  input  logic             sd_in,
  output logic             sd_out,
  input  dmem_ring_cmd_t   cmd_in,
  input  logic [CW-1:0]    ch_in,
  input  logic [AW-1:0]    addr_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] ext_in,
  output logic [WIDTH-1:0] d_out,
  output logic             valid_out,
  output logic             busy_out
);

  localparam int TOTAL = CHANNELS * DEPTH * WIDTH;

  logic [WIDTH-1:0] mem  [CHANNELS][DEPTH];
  logic [AW-1:0]    head [CHANNELS];

  // FSM state is kept in a named enum signal so checkers can bind to it.
  dmem_ring_state_t state, state_next;
  logic [AW-1:0]    clr_cnt;
  logic [CW-1:0]    clr_ch;

  logic             accept;
  logic             addr_ok;
  logic             ch_ok;
  logic             rng_ok;
  logic             clr_start;

  logic [AW-1:0]    head_sel;
  logic [AW-1:0]    push_ptr;
  logic [AW-1:0]    rel_addr;

  logic             wr_en;
  logic [CW-1:0]    wr_ch;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_word;

  logic [TOTAL-1:0] scan_flat;
  logic [TOTAL-1:0] scan_next;

  assign busy_out  = (state == ST_CLEAR);
  assign accept    = !sde_in && (state == ST_IDLE);
  assign addr_ok   = ({1'b0, addr_in} < (AW+1)'(DEPTH));
  assign ch_ok     = ({1'b0, ch_in} < (CW+1)'(CHANNELS));
  assign rng_ok    = addr_ok && ch_ok;
  // A clear of a non-existent channel is dropped like any other bad access.
  assign clr_start = accept && (cmd_in == DMEM_CLR) && ch_ok;
  assign sd_out    = scan_flat[TOTAL-1];

  // Head pointer of the addressed channel (0 when the channel is out of range).
  always_comb begin
    head_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_in == CW'(c)) head_sel = head[c];
    end
  end

  dmem_ring_wrap #(.DEPTH(DEPTH)) u_wrap (
    .ptr (head_sel),
    .off (addr_in),
    .inc (push_ptr),
    .sub (rel_addr)
  );

  // Single write port shared by the clear sweep, WRITE and PUSH.
  always_comb begin
    wr_en   = 1'b0;
    wr_ch   = ch_in;
    wr_addr = addr_in;
    wr_data = d_in;
    if (!sde_in) begin
      if (state == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_ch   = clr_ch;
        wr_addr = clr_cnt;
        wr_data = '0;
      end else if (rng_ok) begin
        case (cmd_in)
          DMEM_WRITE: wr_en = 1'b1;
          DMEM_PUSH: begin
            wr_en   = 1'b1;
            wr_addr = push_ptr;
            wr_data = ext_in;
          end
          default: wr_en = 1'b0;
        endcase
      end
    end
  end

  // Read port: absolute or age-relative address; out-of-range reads give 0.
  always_comb begin
    rd_en   = accept && ((cmd_in == DMEM_READ) || (cmd_in == DMEM_READREL));
    rd_addr = (cmd_in == DMEM_READREL) ? rel_addr : addr_in;
    rd_word = '0;
    if (rng_ok) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int w = 0; w < DEPTH; w++) begin
          if (ch_in == CW'(c) && rd_addr == AW'(w)) rd_word = mem[c][w];
        end
      end
    end
  end

  // Flatten memory into scan order (bit, then word, then channel) and shift.
  always_comb begin
    scan_flat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int w = 0; w < DEPTH; w++) begin
        scan_flat[(c*DEPTH + w)*WIDTH +: WIDTH] = mem[c][w];
      end
    end
    scan_next = {scan_flat[TOTAL-2:0], sd_in};
  end

  // Memory update: reset, then scan shift, then the single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int w = 0; w < DEPTH; w++) mem[c][w] <= '0;
      end
    end else if (sde_in) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[c][w] <= scan_next[(c*DEPTH + w)*WIDTH +: WIDTH];
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int w = 0; w < DEPTH; w++) begin
          if (wr_ch == CW'(c) && wr_addr == AW'(w)) mem[c][w] <= wr_data;
        end
      end
    end
  end

  // Head pointers advance on an in-range PUSH and return to 0 on CLR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) head[c] <= '0;
    end else if (accept && ch_ok) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_in == CW'(c)) begin
          if (cmd_in == DMEM_PUSH && addr_ok) head[c] <= push_ptr;
          else if (cmd_in == DMEM_CLR)        head[c] <= '0;
        end
      end
    end
  end

  // Sweep bookkeeping: latch target on start, advance only while unpaused.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
      clr_ch  <= '0;
    end else if (clr_start) begin
      clr_cnt <= '0;
      clr_ch  <= ch_in;
    end else if (state == ST_CLEAR && !sde_in) begin
      clr_cnt <= (clr_cnt == AW'(DEPTH - 1)) ? '0 : clr_cnt + AW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clr_start) state_next = ST_CLEAR;
      ST_CLEAR: if (!sde_in && clr_cnt == AW'(DEPTH - 1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registered read data; d_out holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_en;
      if (rd_en) d_out <= rd_word;
    end
  end

endmodule
